decay_scheduler: RTL and testbench

DECAY_SCHEDULER -- requirements
Module: decay_scheduler

---
 rtl/decay_pkg.sv | 25 ++
 rtl/potential_regfile.sv | 42 ++++
 rtl/decay_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_decay_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decay_pkg.sv
// rtl/decay_pkg.sv - shared neuron count, decay rate encodings and FSM state encoding
package decay_pkg;

  localparam int N_NEURONS = 10;

  localparam logic [3:0] RATE_DIV1   = 4'b0001;
  localparam logic [3:0] RATE_DIV2   = 4'b0010;
  localparam logic [3:0] RATE_DIV4   = 4'b0100;
  localparam logic [3:0] RATE_DIV8   = 4'b1000;
  localparam logic [3:0] RATE_DIV2P4 = 4'b0011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A unity rate or a signed zero leaves the potential unchanged, so the datapath is skipped.
  function automatic logic is_bypass(input logic [3:0] rate, input logic [30:0] magnitude);
    return (rate == RATE_DIV1) || (magnitude == 31'd0);
  endfunction

endpackage

// File: rtl/potential_regfile.sv
// rtl/potential_regfile.sv - per-neuron potential and decay rate storage
// One write port (potential with optional rate) and one asynchronous read port.
module potential_regfile
  import decay_pkg::*;
#(
  parameter int DEPTH = N_NEURONS
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        rate_we,
  input  logic [3:0]  wrate,
  input  logic [3:0]  raddr,
  output logic [31:0] rpot,
  output logic [3:0]  rrate
);

  logic [31:0] pot_q  [DEPTH];
  logic [3:0]  rate_q [DEPTH];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        pot_q[i]  <= '0;
        rate_q[i] <= RATE_DIV1;
      end
    end else begin
      if (we) begin
        pot_q[waddr] <= wdata;
      end
      if (we && rate_we) begin
        rate_q[waddr] <= wrate;
      end
    end
  end

  assign rpot  = pot_q[raddr];
  assign rrate = rate_q[raddr];

endmodule

// File: rtl/decay_scheduler.sv
// rtl/decay_scheduler.sv - sweeps every neuron once per timestep through a shared decay datapath
// Host cfg/acc writes share the regfile write port with sweep write-back and only land while idle.
module decay_scheduler
  import decay_pkg::*;
#(
  parameter int N_NEURONS = decay_pkg::N_NEURONS,
  parameter int TS_WIDTH  = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                timestep_start,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [31:0]         cfg_data,
  input  logic [3:0]          cfg_rate,
  input  logic                acc_valid,
  input  logic [3:0]          acc_addr,
  input  logic [31:0]         acc_data,
  output logic                acc_ready,
  output logic                dec_req,
  output logic [31:0]         dec_operand,
  output logic [3:0]          dec_rate,
  input  logic                dec_ack,
  input  logic [31:0]         dec_result,
  output logic                out_valid,
  output logic [3:0]          out_addr,
  output logic [31:0]         out_potential,
  output logic                busy,
  output logic                sweep_done,
  output logic                overrun,
  output logic [TS_WIDTH-1:0] timestep_count
);

  localparam logic [3:0] LAST_IDX = 4'(N_NEURONS - 1);

  state_t              state_q, state_d;
  logic [3:0]          idx_q;
  logic [31:0]         result_q;
  logic [31:0]         cap_data;
  logic                capture;
  logic                req_active;
  logic [TS_WIDTH-1:0] ts_q;
  logic                overrun_q;
  logic [31:0]         rd_pot;
  logic [3:0]          rd_rate;
  logic                bypass;
  logic                cfg_ok, acc_ok;
  logic                wr_en, wr_rate_en;
  logic [3:0]          wr_addr;
  logic [31:0]         wr_data;

  assign busy      = (state_q != IDLE);
  assign acc_ready = ~busy;
  assign bypass    = is_bypass(rd_rate, rd_pot[30:0]);
  assign cfg_ok    = cfg_we && !busy && (cfg_addr <= LAST_IDX);
  assign acc_ok    = acc_valid && !busy && (acc_addr <= LAST_IDX);

  // Host writes only pass while idle, so they never collide with the WRITE-state write-back.
  always_comb begin
    wr_en      = 1'b0;
    wr_rate_en = 1'b0;
    wr_addr    = idx_q;
    wr_data    = result_q;
    if (state_q == WRITE) begin
      wr_en = 1'b1;
    end else if (cfg_ok) begin
      wr_en      = 1'b1;
      wr_rate_en = 1'b1;
      wr_addr    = cfg_addr;
      wr_data    = cfg_data;
    end else if (acc_ok) begin
      wr_en   = 1'b1;
      wr_addr = acc_addr;
      wr_data = acc_data;
    end
  end

  potential_regfile #(
    .DEPTH(N_NEURONS)
  ) u_regfile (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .we     (wr_en),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .rate_we(wr_rate_en),
    .wrate  (cfg_rate),
    .raddr  (idx_q),
    .rpot   (rd_pot),
    .rrate  (rd_rate)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_active = 1'b0;
    capture    = 1'b0;
    cap_data   = rd_pot;
    case (state_q)
      IDLE: begin
        if (timestep_start) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bypass) begin
          capture = 1'b1;
          state_d = WRITE;
        end else begin
          req_active = 1'b1;
          if (dec_ack) begin
            capture  = 1'b1;
            cap_data = dec_result;
            state_d  = WRITE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req_active = 1'b1;
        if (dec_ack) begin
          capture  = 1'b1;
          cap_data = dec_result;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        state_d = (idx_q == LAST_IDX) ? DONE : ISSUE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q     <= '0;
      result_q  <= '0;
      ts_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        result_q <= cap_data;
      end
      if (state_q == IDLE && timestep_start) begin
        idx_q <= '0;
      end else if (state_q == WRITE && idx_q != LAST_IDX) begin
        idx_q <= idx_q + 4'd1;
      end
      if (state_q == DONE) begin
        ts_q <= ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
      end
      if (timestep_start && busy) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Request fields read straight from the regfile; they stay put because idx and storage are frozen in WAIT.
  assign dec_req        = req_active;
  assign dec_operand    = req_active ? rd_pot : '0;
  assign dec_rate       = req_active ? rd_rate : '0;
  assign out_valid      = (state_q == WRITE);
  assign out_addr       = out_valid ? idx_q : '0;
  assign out_potential  = out_valid ? result_q : '0;
  assign sweep_done     = (state_q == DONE);
  assign overrun        = overrun_q;
  assign timestep_count = ts_q;

endmodule

// File: tb/tb_decay_scheduler.sv
// tb/tb_decay_scheduler.sv - randomized self-checking bench for decay_scheduler
// Expected sweeps come from a per-neuron array model and spec-level cycle costs.
module tb_decay_scheduler;

  localparam int N   = 10;
  localparam int TSW = 4;
  localparam logic [3:0] R1  = 4'b0001;
  localparam logic [3:0] R2  = 4'b0010;
  localparam logic [3:0] R4  = 4'b0100;
  localparam logic [3:0] R8  = 4'b1000;
  localparam logic [3:0] R24 = 4'b0011;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            timestep_start = 1'b0;
  logic            cfg_we = 1'b0;
  logic [3:0]      cfg_addr = '0;
  logic [31:0]     cfg_data = '0;
  logic [3:0]      cfg_rate = '0;
  logic            acc_valid = 1'b0;
  logic [3:0]      acc_addr = '0;
  logic [31:0]     acc_data = '0;
  logic            acc_ready;
  logic            dec_req;
  logic [31:0]     dec_operand;
  logic [3:0]      dec_rate;
  logic            dec_ack;
  logic [31:0]     dec_result;
  logic            out_valid;
  logic [3:0]      out_addr;
  logic [31:0]     out_potential;
  logic            busy;
  logic            sweep_done;
  logic            overrun;
  logic [TSW-1:0]  timestep_count;

  int n_checks = 0;
  int n_fail   = 0;

  decay_scheduler #(
    .N_NEURONS(N),
    .TS_WIDTH (TSW)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .timestep_start(timestep_start),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_rate      (cfg_rate),
    .acc_valid     (acc_valid),
    .acc_addr      (acc_addr),
    .acc_data      (acc_data),
    .acc_ready     (acc_ready),
    .dec_req       (dec_req),
    .dec_operand   (dec_operand),
    .dec_rate      (dec_rate),
    .dec_ack       (dec_ack),
    .dec_result    (dec_result),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .out_potential (out_potential),
    .busy          (busy),
    .sweep_done    (sweep_done),
    .overrun       (overrun),
    .timestep_count(timestep_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench-owned decay datapath: exponent shift for the power-of-two rates, an arbitrary mix otherwise.
  function automatic logic [31:0] dp_fn(input logic [31:0] x, input logic [3:0] r);
    int sh;
    case (r)
      R2:      sh = 1;
      R4:      sh = 2;
      R8:      sh = 3;
      default: return x ^ {28'h0000100, r};
    endcase
    if (int'(x[30:23]) > sh) return {x[31], x[30:23] - 8'(sh), x[22:0]};
    return {x[31], 31'h0};
  endfunction

  logic        dp_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] dp_res = '0;
  int          dp_lat = 1;
  bit          dp_en = 1'b1;
  int          dp_cnt = 0;
  logic [31:0] dp_op = '0;
  logic [3:0]  dp_rt = '0;

  assign dec_ack    = dp_ack | force_ack;
  assign dec_result = dp_res;

  always @(negedge CLK) begin
    if (dp_en && dec_req) begin
      if (dp_cnt == 0) begin
        dp_op = dec_operand;
        dp_rt = dec_rate;
      end else begin
        check("dec_hold", {28'h0, dec_operand, dec_rate}, {28'h0, dp_op, dp_rt});
      end
      dp_ack = (dp_cnt >= dp_lat);
      dp_res = dp_fn(dp_op, dp_rt);
      dp_cnt++;
    end else begin
      dp_ack = 1'b0;
      dp_cnt = 0;
    end
  end

  int          cyc = 0;
  int          got_addr[$];
  logic [31:0] got_pot[$];
  int          got_cyc[$];
  int          done_cyc[$];
  int          req_cycles = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (out_valid) begin
      got_addr.push_back(int'(out_addr));
      got_pot.push_back(out_potential);
      got_cyc.push_back(cyc);
    end
    if (sweep_done) done_cyc.push_back(cyc);
    if (dec_req) req_cycles++;
  end

  logic [31:0] m_pot  [N];
  logic [3:0]  m_rate [N];
  int          m_ts;
  bit          m_ovr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pot[i]  = '0;
      m_rate[i] = R1;
    end
    m_ts  = 0;
    m_ovr = 1'b0;
  endfunction

  function automatic void model_write(input logic cw, input logic [3:0] ca, input logic [31:0] cd,
                                      input logic [3:0] cr, input logic av, input logic [3:0] aa,
                                      input logic [31:0] ad);
    if (av && int'(aa) < N) m_pot[aa] = ad;
    if (cw && int'(ca) < N) begin
      m_pot[ca]  = cd;
      m_rate[ca] = cr;
    end
  endfunction

  task automatic clr_inputs();
    cfg_we         = 1'b0;
    acc_valid      = 1'b0;
    timestep_start = 1'b0;
  endtask

  task automatic drive_wr(input logic cw, input logic [3:0] ca, input logic [31:0] cd, input logic [3:0] cr,
                          input logic av, input logic [3:0] aa, input logic [31:0] ad, input bit accepted);
    cfg_we = cw; cfg_addr = ca; cfg_data = cd; cfg_rate = cr;
    acc_valid = av; acc_addr = aa; acc_data = ad;
    if (accepted) model_write(cw, ca, cd, cr, av, aa, ad);
  endtask

  task automatic write_one(input logic cw, input logic [3:0] ca, input logic [31:0] cd, input logic [3:0] cr,
                           input logic av, input logic [3:0] aa, input logic [31:0] ad);
    @(negedge CLK);
    drive_wr(cw, ca, cd, cr, av, aa, ad, 1'b1);
    @(negedge CLK);
    clr_inputs();
  endtask

  // Called on a negedge; any write already driven on this edge lands before the sweep reads it.
  task automatic sweep(input int ovr_at, input bit busy_wr);
    int          st;
    int          cost_sum;
    int          exp_req;
    int          t;
    bit          byp;
    logic [31:0] res;
    logic [31:0] exp_p[$];
    int          exp_c[$];
    got_addr.delete(); got_pot.delete(); got_cyc.delete(); done_cyc.delete();
    req_cycles = 0;
    cost_sum = 0;
    exp_req = 0;
    timestep_start = 1'b1;
    st = cyc;
    for (int i = 0; i < N; i++) begin
      byp = (m_rate[i] == R1) || (m_pot[i][30:0] == 31'd0);
      res = byp ? m_pot[i] : dp_fn(m_pot[i], m_rate[i]);
      cost_sum += byp ? 2 : 2 + dp_lat;
      exp_req  += byp ? 0 : 1 + dp_lat;
      exp_p.push_back(res);
      exp_c.push_back(cost_sum);
      m_pot[i] = res;
    end
    m_ts = (m_ts + 1) % (1 << TSW);
    @(negedge CLK);
    clr_inputs();
    check("busy_in_sweep", busy, 1);
    check("acc_ready_in_sweep", acc_ready, 0);
    if (busy_wr) begin
      @(negedge CLK);
      drive_wr(1'b1, 4'd3, 32'h1234_5678, R8, 1'b1, 4'd2, 32'hDEAD_BEEF, 1'b0);
      check("acc_ready_drop", acc_ready, 0);
      @(negedge CLK);
      clr_inputs();
    end
    if (ovr_at > 0) begin
      repeat (ovr_at) @(negedge CLK);
      timestep_start = 1'b1;
      m_ovr = 1'b1;
      @(negedge CLK);
      timestep_start = 1'b0;
    end
    t = 0;
    while (done_cyc.size() == 0 && t < 400) begin
      @(negedge CLK);
      t++;
    end
    repeat ((ovr_at > 0) ? 30 : 3) @(negedge CLK);
    check("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("done_cycle", done_cyc[0] - st, cost_sum + 1);
    check("out_count", got_addr.size(), N);
    for (int i = 0; i < N && i < got_addr.size(); i++) begin
      check($sformatf("out_addr[%0d]", i), got_addr[i], i);
      check($sformatf("out_pot[%0d]", i), got_pot[i], exp_p[i]);
      check($sformatf("out_cyc[%0d]", i), got_cyc[i] - st, exp_c[i]);
    end
    check("dec_req_cycles", req_cycles, exp_req);
    check("ts_count", timestep_count, m_ts);
    check("overrun", overrun, m_ovr);
    check("idle_after", {busy, acc_ready}, 2'b01);
  endtask

  function automatic logic [31:0] rnd_pot();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rnd_rate();
    case ($urandom_range(0, 5))
      0:       return R1;
      1:       return R2;
      2:       return R4;
      3:       return R8;
      4:       return R24;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [3:0] ca, aa;
    int mode;
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_flags", {dec_req, out_valid, busy, sweep_done, overrun, acc_ready}, 6'b000001);
    check("rst_data", {dec_operand, dec_rate, out_addr, out_potential}, 72'h0);
    check("rst_ts", timestep_count, 0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // single neuron halved through a 2-cycle datapath
    dp_lat = 2;
    write_one(1'b1, 4'd6, 32'h4165_EB85, R2, 1'b0, 4'd0, 32'h0);
    @(negedge CLK);
    sweep(0, 1'b0);
    check("n6_div2", got_pot.size() > 6 ? got_pot[6] : 32'hxxxx_xxxx, 32'h40E5_EB85);
    check("ts_first", timestep_count, 1);

    // every neuron at unity rate: pure bypass sweep
    for (int i = 0; i < N; i++) write_one(1'b1, 4'(i), $urandom | 32'h0080_0000, R1, 1'b0, 4'd0, 32'h0);
    @(negedge CLK);
    sweep(0, 1'b0);

    // divide-by-4 twice in a row
    dp_lat = 1;
    write_one(1'b1, 4'd6, 32'h4165_EB85, R4, 1'b0, 4'd0, 32'h0);
    @(negedge CLK);
    sweep(0, 1'b0);
    check("n6_div4_a", got_pot.size() > 6 ? got_pot[6] : 32'hxxxx_xxxx, 32'h4065_EB85);
    @(negedge CLK);
    sweep(0, 1'b0);
    check("n6_div4_b", got_pot.size() > 6 ? got_pot[6] : 32'hxxxx_xxxx, 32'h3F65_EB85);

    // overrun start, then host writes while busy
    @(negedge CLK);
    sweep(5, 1'b0);
    check("overrun_sticky", overrun, 1);
    write_one(1'b1, 4'd2, 32'h4200_0000, R2, 1'b0, 4'd0, 32'h0);
    @(negedge CLK);
    sweep(0, 1'b1);
    @(negedge CLK);
    sweep(0, 1'b0);

    // write and start in the same cycle, same-address cfg/acc, out-of-range addresses
    @(negedge CLK);
    drive_wr(1'b1, 4'd4, 32'h4300_0000, R8, 1'b0, 4'd0, 32'h0, 1'b1);
    sweep(0, 1'b0);
    write_one(1'b1, 4'd5, 32'h4480_0000, R24, 1'b1, 4'd5, 32'h3F00_0000);
    write_one(1'b1, 4'd12, 32'h4000_0000, R2, 1'b1, 4'd7, 32'h4100_0000);
    write_one(1'b1, 4'd8, 32'h4500_0000, R4, 1'b1, 4'd15, 32'h4600_0000);
    dp_lat = 0;
    @(negedge CLK);
    sweep(0, 1'b0);

    // randomized configuration and datapath latency
    for (int k = 0; k < 8; k++) begin
      dp_lat = $urandom_range(0, 3);
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        mode = $urandom_range(0, 3);
        ca = 4'($urandom_range(0, 15));
        aa = (mode == 2) ? ca : (int'(ca) < N ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)));
        write_one(mode != 1, ca, rnd_pot(), rnd_rate(), mode != 0, aa, rnd_pot());
      end
      @(negedge CLK);
      sweep(0, 1'b0);
    end

    // drive the counter to its top value and across the wrap
    t = 0;
    while (m_ts != (1 << TSW) - 1 && t < 20) begin
      @(negedge CLK);
      sweep(0, 1'b0);
      t++;
    end
    @(negedge CLK);
    sweep(0, 1'b0);
    check("ts_wrap", timestep_count, 0);

    // reset while waiting on the datapath, then a stale ack
    dp_lat = 1;
    write_one(1'b1, 4'd0, 32'h4120_0000, R2, 1'b0, 4'd0, 32'h0);
    dp_en = 1'b0;
    @(negedge CLK);
    timestep_start = 1'b1;
    @(negedge CLK);
    timestep_start = 1'b0;
    t = 0;
    while (!dec_req && t < 10) begin
      @(negedge CLK);
      t++;
    end
    repeat (2) @(negedge CLK);
    check("wait_req_held", dec_req, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_async_req", dec_req, 0);
    check("rst_async_flags", {busy, acc_ready, out_valid}, 3'b010);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    got_addr.delete(); got_pot.delete(); got_cyc.delete();
    @(negedge CLK);
    force_ack = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    repeat (4) @(negedge CLK);
    check("late_ack_no_out", got_addr.size(), 0);
    check("late_ack_idle", busy, 0);
    dp_en = 1'b1;
    @(negedge CLK);
    sweep(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
